// File: rtl/riscv32_pkg.sv
// Shared RV32 pipeline definitions: hazard FSM encoding and pipeline-register constants.
package riscv32_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    SQUASH   = 2'd2,
    MEM_WAIT = 2'd3
  } hazard_state_e;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          CTRL_BUNDLE_W = 14;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: +1 per cycle with inc high, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect squashes and dmem freezes,
// all resolved combinationally in the cycle they are seen, plus lost-cycle counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES    = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_dec,
  input  logic [4:0]       rs2_dec,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             redirect_ex,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             if_dec_en,
  output logic             if_dec_flush,
  output logic             dec_ex_bubble,
  output logic             ex_mem_en,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  import riscv32_pkg::*;

  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LU_LD    = 3'(LOAD_USE_CYCLES - 1);

  hazard_state_e state_q, state_d, saved_state_q, saved_state_d, eff_state;
  logic [2:0]    cnt_q, cnt_d, saved_cnt_q, saved_cnt_d, eff_cnt;
  logic          lu;
  logic          stall_inc, flush_inc, wait_inc;

  assign lu = ex_mem_read && ex_reg_write && (ex_rd != 5'd0) &&
              ((rs1_used && (rs1_dec == ex_rd)) || (rs2_used && (rs2_dec == ex_rd)));

  // On the cycle dmem_busy falls the frozen operation resumes immediately,
  // so the saved context stands in for MEM_WAIT.
  assign eff_state = (state_q == MEM_WAIT) ? saved_state_q : state_q;
  assign eff_cnt   = (state_q == MEM_WAIT) ? saved_cnt_q   : cnt_q;

  always_comb begin
    pc_en         = 1'b1;
    if_dec_en     = 1'b1;
    ex_mem_en     = 1'b1;
    if_dec_flush  = 1'b0;
    dec_ex_bubble = 1'b0;
    state_d       = eff_state;
    cnt_d         = eff_cnt;
    saved_state_d = saved_state_q;
    saved_cnt_d   = saved_cnt_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    wait_inc      = 1'b0;

    if (reset) begin
      if_dec_flush  = 1'b1;
      dec_ex_bubble = 1'b1;
      state_d       = RUN;
      cnt_d         = '0;
    end else if (dmem_busy) begin
      pc_en     = 1'b0;
      if_dec_en = 1'b0;
      ex_mem_en = 1'b0;
      state_d   = MEM_WAIT;
      cnt_d     = cnt_q;
      wait_inc  = 1'b1;
      if (state_q != MEM_WAIT) begin
        saved_state_d = state_q;
        saved_cnt_d   = cnt_q;
      end
    end else if (redirect_ex) begin
      if_dec_flush  = 1'b1;
      dec_ex_bubble = 1'b1;
      cnt_d         = FLUSH_LD;
      state_d       = (FLUSH_LD != 3'd0) ? SQUASH : RUN;
      flush_inc     = 1'b1;
    end else begin
      case (eff_state)
        LU_STALL: begin
          pc_en         = 1'b0;
          if_dec_en     = 1'b0;
          dec_ex_bubble = 1'b1;
          cnt_d         = eff_cnt - 3'd1;
          state_d       = (eff_cnt == 3'd1) ? RUN : LU_STALL;
          stall_inc     = 1'b1;
        end
        SQUASH: begin
          dec_ex_bubble = 1'b1;
          cnt_d         = eff_cnt - 3'd1;
          state_d       = (eff_cnt == 3'd1) ? RUN : SQUASH;
          flush_inc     = 1'b1;
        end
        RUN: begin
          if (lu) begin
            pc_en         = 1'b0;
            if_dec_en     = 1'b0;
            dec_ex_bubble = 1'b1;
            cnt_d         = LU_LD;
            state_d       = (LU_LD != 3'd0) ? LU_STALL : RUN;
            stall_inc     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      saved_state_q <= RUN;
      saved_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      saved_state_q <= saved_state_d;
      saved_cnt_q   <= saved_cnt_d;
    end
  end

  assign state_o = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wait_inc),
    .count (mem_wait_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. Watches the decode, execute and memory stages and drives the enable, flush and bubble controls of the IF/DEC, DEC/EX and EX/MEM pipeline registers. Three hazards are resolved here:
- load-use RAW hazards, by stalling;
- control redirects, by squashing a configurable number of wrong-path slots;
- data-memory wait states, by freezing the pipeline.

It also keeps saturating performance counters of lost cycles.

## Interface
Parameters:
- FLUSH_CYCLES, 2: DEC/EX slots forced to bubble after a redirect, counting the redirect cycle. Legal range 1..7.
- LOAD_USE_CYCLES, 1: bubbles inserted per load-use hazard. Legal range 1..3.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rs1_dec, rs2_dec  in  5 each  source registers of the instruction in DEC
- rs1_used, rs2_used  in  1 each  instruction in DEC reads rs1 / rs2
- ex_rd  in  5  destination register in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_reg_write  in  1  instruction in EX writes rd
- redirect_ex  in  1  branch taken or jump resolved in EX this cycle
- dmem_busy  in  1  data memory has not completed the MEM-stage access
- pc_en  out  1  PC register update enable
- if_dec_en  out  1  IF/DEC register load enable
- if_dec_flush  out  1  IF/DEC loads a NOP
- dec_ex_bubble  out  1  DEC/EX loads all-zero control (drives the stall/flush input of that register)
- ex_mem_en  out  1  EX/MEM register load enable
- state_o  out  2  current FSM state, for debug
- stall_cnt, flush_cnt, mem_wait_cnt  out  CNT_W each  saturating counts of cycles lost to each cause

## Operation
FSM states: RUN=0, LU_STALL=1, SQUASH=2, MEM_WAIT=3.

Hazard definitions:
- A load-use hazard (lu) exists when ex_mem_read && ex_reg_write && ex_rd != 0 && ((rs1_used && rs1_dec == ex_rd) || (rs2_used && rs2_dec == ex_rd)).
- x0 never creates a hazard.

Event priority in each cycle, highest first: reset, dmem_busy, redirect_ex, lu.
- dmem_busy, from any state: freeze.
  - Outputs: pc_en = if_dec_en = ex_mem_en = 0, dec_ex_bubble = 0, flushes = 0.
  - Next state is MEM_WAIT. The state held before entering MEM_WAIT and its remaining count are saved and restored when dmem_busy falls.
- redirect_ex, in RUN / LU_STALL / SQUASH:
  - if_dec_flush = 1 and dec_ex_bubble = 1; pc_en and if_dec_en = 1 so the target is fetched.
  - The count is loaded with FLUSH_CYCLES-1. If that is non-zero, go to SQUASH, otherwise go to RUN.
  - A pending load-use stall is discarded.
- lu in RUN:
  - pc_en = if_dec_en = 0, dec_ex_bubble = 1.
  - The count is loaded with LOAD_USE_CYCLES-1. If that is non-zero, go to LU_STALL, otherwise stay in RUN.
- LU_STALL: same outputs as the lu cycle. The count decrements each cycle; at 1, return to RUN.
- SQUASH: dec_ex_bubble = 1, all enables = 1. The count decrements each cycle; at 1, return to RUN.
- RUN with no event: all enables = 1, bubble and flushes = 0.

Performance counters:
- Each counter increments by 1 per cycle of its cause: stall_cnt for a lu cycle or LU_STALL, flush_cnt for a redirect cycle or SQUASH, mem_wait_cnt while dmem_busy.
- Counters saturate at all-ones and never wrap.

## Timing
- All outputs are combinational from the current state, the count and the same-cycle inputs. Hazard response has zero-cycle latency.
- State, count, the saved state/count and the counters update on posedge clk.
- Reset values:
  - State RUN, counts 0, counters 0.
  - While reset is high: pc_en = if_dec_en = ex_mem_en = 1, dec_ex_bubble = 1, if_dec_flush = 1.
- Reset asserted mid-stall, mid-squash or mid-wait abandons the operation. The first cycle after reset deasserts is RUN.
- redirect_ex and lu in the same cycle: the redirect wins and lu is ignored, because the dependent instruction is wrong-path.
- dmem_busy arriving during SQUASH or LU_STALL: the count does not decrement while frozen. The operation resumes with the same remaining count.
- redirect_ex is sampled only when dmem_busy = 0; EX holds the value stable during a freeze.

## Structure
- Shared package riscv32_pkg holds:
  - the hazard_state_e enum (2-bit);
  - localparam NOP_INSTR = 32'h0000_0013;
  - the control-bundle width constant already used by the pipeline registers.
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc; output count), instantiated three times for the performance counters.

## Test plan
- Load-use: EX holds lw x5 (ex_mem_read=1, ex_rd=5); DEC has rs1_dec=5, rs1_used=1; LOAD_USE_CYCLES=1.
  - Required: pc_en=0, if_dec_en=0, dec_ex_bubble=1 for exactly 1 cycle, then RUN; stall_cnt=1.
- x0 and unused operands:
  - ex_rd=0 with a matching rs1_dec: no stall.
  - rs2_dec=ex_rd with rs2_used=0: no stall.
- Redirect with FLUSH_CYCLES=3: pulse redirect_ex for 1 cycle.
  - Required: if_dec_flush=1 for 1 cycle; dec_ex_bubble=1 for 3 consecutive cycles; flush_cnt=3.
- Redirect and lu in the same cycle.
  - Required: squash only; stall_cnt unchanged; state_o=SQUASH next cycle (FLUSH_CYCLES=2).
- dmem_busy for 4 cycles in the middle of SQUASH (count=1).
  - Required: all enables=0 for 4 cycles; mem_wait_cnt=4; one more bubble cycle after release, then RUN.
- Saturation and reset:
  - With CNT_W=4, hold dmem_busy for 20 cycles: mem_wait_cnt=15.
  - Assert reset in LU_STALL: next state RUN and all counters 0.
